// File: rtl/dma_burst_splitter.sv
// dma_burst_splitter: splits one transfer into sub-commands that never cross a MAX_BYTES
// boundary, keeps up to MAX_OUTSTANDING in flight, merges sub-statuses. Option: DMA_SPLITTER_ABORT_EN.
module dma_burst_splitter #(
  parameter int ADDR_W          = 32,
  parameter int LEN_W           = 32,
  parameter int BEAT_BYTES      = 8,
  parameter int MAX_BEATS       = 256,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SUB_W           = $clog2(BEAT_BYTES * MAX_BEATS) + 1
) (
  input  logic              ACLK,
  input  logic              ARESETn,
`ifdef DMA_SPLITTER_ABORT_EN
  input  logic              abort,
`endif
  input  logic              trans_valid,
  output logic              trans_ready,
  input  logic [ADDR_W-1:0] trans_addr,
  input  logic [LEN_W-1:0]  trans_bytes,
  output logic              tstat_valid,
  input  logic              tstat_ready,
  output logic [1:0]        tstat_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [SUB_W-1:0]  cmd_bytes,
  input  logic              stat_valid,
  output logic              stat_ready,
  input  logic [1:0]        stat_data
);

  localparam int MAX_BYTES = BEAT_BYTES * MAX_BEATS;
  localparam int OFS_W     = $clog2(MAX_BYTES);
  localparam int OUT_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OUT_W-1:0] OUT_MAX     = OUT_W'(MAX_OUTSTANDING);
  localparam logic [SUB_W-1:0] MAX_BYTES_V = SUB_W'(MAX_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_STAT  = 2'd3
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ADDR_W-1:0]  cur_addr_r, nxt_addr_s;
  logic [LEN_W-1:0]   rem_r, nxt_rem_s;
  logic [SUB_W-1:0]   cmd_bytes_r;
  logic [1:0]         err_r;
  logic [OUT_W-1:0]   out_r, out_nxt_s;
  logic               trans_hs_s, cmd_hs_s, stat_hs_s, tstat_hs_s, abort_s;

  // Chunk length: whatever is left, capped by the room up to the next MAX_BYTES boundary.
  function automatic logic [SUB_W-1:0] chunk_f(input logic [ADDR_W-1:0] addr,
                                               input logic [LEN_W-1:0]  rem);
    logic [SUB_W-1:0] room;
    room = MAX_BYTES_V - {1'b0, addr[OFS_W-1:0]};
    if (rem < LEN_W'(room)) chunk_f = rem[SUB_W-1:0];
    else                    chunk_f = room;
  endfunction

`ifdef DMA_SPLITTER_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign trans_hs_s = trans_valid & trans_ready;
  assign cmd_hs_s   = cmd_valid & cmd_ready;
  assign stat_hs_s  = stat_valid & stat_ready;
  assign tstat_hs_s = tstat_valid & tstat_ready;
  assign nxt_addr_s = cur_addr_r + ADDR_W'(cmd_bytes_r);
  assign nxt_rem_s  = rem_r - LEN_W'(cmd_bytes_r);
  assign cmd_addr   = cur_addr_r;
  assign cmd_bytes  = cmd_bytes_r;

  // Outstanding count: a simultaneous issue and return cancel out.
  always_comb begin
    out_nxt_s = out_r;
    case ({cmd_hs_s, stat_hs_s})
      2'b10:   out_nxt_s = out_r + {{(OUT_W-1){1'b0}}, 1'b1};
      2'b01:   out_nxt_s = out_r - {{(OUT_W-1){1'b0}}, 1'b1};
      default: out_nxt_s = out_r;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_r <= ST_IDLE;
    else          state_r <= state_nxt_s;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (trans_hs_s) state_nxt_s = (trans_bytes == {LEN_W{1'b0}}) ? ST_STAT : ST_ISSUE;
        else            state_nxt_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if ((err_r != 2'b00) || abort_s)                   state_nxt_s = ST_DRAIN;
        else if (cmd_hs_s && (nxt_rem_s == {LEN_W{1'b0}})) state_nxt_s = ST_DRAIN;
        else                                               state_nxt_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if (out_nxt_s == {OUT_W{1'b0}}) state_nxt_s = ST_STAT;
        else                            state_nxt_s = ST_DRAIN;
      end
      ST_STAT: begin
        if (tstat_hs_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_STAT;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode; a latched error blocks further issue.
  always_comb begin
    trans_ready = 1'b0;
    cmd_valid   = 1'b0;
    stat_ready  = 1'b0;
    tstat_valid = 1'b0;
    tstat_data  = 2'b00;
    case (state_r)
      ST_IDLE:  trans_ready = 1'b1;
      ST_ISSUE: begin
        cmd_valid  = (out_r < OUT_MAX) && (err_r == 2'b00);
        stat_ready = (out_r != {OUT_W{1'b0}});
      end
      ST_DRAIN: stat_ready = (out_r != {OUT_W{1'b0}});
      ST_STAT: begin
        tstat_valid = 1'b1;
        tstat_data  = err_r;
      end
      default: trans_ready = 1'b0;
    endcase
  end

  // Datapath: cursor, remainder, pre-computed next chunk, first-error merge, outstanding.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      cur_addr_r  <= {ADDR_W{1'b0}};
      rem_r       <= {LEN_W{1'b0}};
      cmd_bytes_r <= {SUB_W{1'b0}};
      err_r       <= 2'b00;
      out_r       <= {OUT_W{1'b0}};
    end else begin
      out_r <= out_nxt_s;
      if (trans_hs_s) begin
        cur_addr_r  <= trans_addr;
        rem_r       <= trans_bytes;
        cmd_bytes_r <= chunk_f(trans_addr, trans_bytes);
      end else if (cmd_hs_s) begin
        cur_addr_r  <= nxt_addr_s;
        rem_r       <= nxt_rem_s;
        cmd_bytes_r <= chunk_f(nxt_addr_s, nxt_rem_s);
      end
      if (trans_hs_s)
        err_r <= 2'b00;
      else if (stat_hs_s && (stat_data != 2'b00) && (err_r == 2'b00))
        err_r <= stat_data;
      else if (abort_s && (err_r == 2'b00) &&
               ((state_r == ST_ISSUE) || (state_r == ST_DRAIN)))
        err_r <= 2'b11;
    end
  end

endmodule

// File: tb/tb_dma_burst_splitter.sv
// Randomized bench for dma_burst_splitter with a transaction-level scoreboard.
module tb_dma_burst_splitter;
  localparam int MAXB = 2048;
  localparam int MAXO = 4;

  logic        ACLK = 1'b0, ARESETn = 1'b0;
  logic        abort = 1'b0;
  logic        trans_valid = 1'b0, trans_ready;
  logic [31:0] trans_addr = 32'd0, trans_bytes = 32'd0;
  logic        tstat_valid, tstat_ready = 1'b0;
  logic [1:0]  tstat_data;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [31:0] cmd_addr;
  logic [11:0] cmd_bytes;
  logic        stat_valid = 1'b0, stat_ready;
  logic [1:0]  stat_data = 2'b00;

  dma_burst_splitter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
`ifdef DMA_SPLITTER_ABORT_EN
    .abort(abort),
`endif
    .trans_valid(trans_valid), .trans_ready(trans_ready),
    .trans_addr(trans_addr), .trans_bytes(trans_bytes),
    .tstat_valid(tstat_valid), .tstat_ready(tstat_ready), .tstat_data(tstat_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_bytes(cmd_bytes),
    .stat_valid(stat_valid), .stat_ready(stat_ready), .stat_data(stat_data)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard state and stimulus knobs
  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];
  logic [1:0]  force_q[$];
  int          mdl_out, n_cmd, n_total;
  logic [1:0]  mdl_err;
  bit          stop_flag;
  int          rdy_pct = 100, stat_pct = 100, err_pct = 0, tready_pct = 100, hold_cycles = 0;
  bit          abort_after_first = 1'b0;

  // Expected sub-command list: cut at every 2048-byte boundary, 32-bit wrap.
  task automatic build_chunks(input logic [31:0] a, input logic [31:0] n);
    logic [31:0] ca;
    longint      r, room, c;
    exp_addr_q.delete();
    exp_len_q.delete();
    ca = a;
    r  = longint'(n);
    while (r > 0) begin
      room = MAXB - longint'(ca % MAXB);
      c    = (r < room) ? r : room;
      exp_addr_q.push_back(ca);
      exp_len_q.push_back(int'(c));
      ca = ca + 32'(c);
      r  = r - c;
    end
    n_total = exp_addr_q.size();
  endtask

  task automatic run_transfer(input logic [31:0] a, input logic [31:0] n);
    bit          done, pend, abort_done;
    int          cyc;
    logic [31:0] pa;
    logic [11:0] pb;
    build_chunks(a, n);
    mdl_out = 0; mdl_err = 2'b00; stop_flag = 1'b0; n_cmd = 0;
    pend = 1'b0; abort_done = 1'b0; pa = 32'd0; pb = 12'd0;
    stat_valid = 1'b0; cmd_ready = (rdy_pct == 100); tstat_ready = 1'b0; abort = 1'b0;
    trans_addr = a; trans_bytes = n; trans_valid = 1'b1;
    done = 1'b0; cyc = 0;
    while (!done && cyc < 10) begin
      @(negedge ACLK);
      if (trans_ready) done = 1'b1;
      @(posedge ACLK); #1;
      cyc++;
    end
    trans_valid = 1'b0;
    check_val("trans_accept", done, 1);
    done = 1'b0; cyc = 0;
    while (!done && cyc < 5000) begin
      @(negedge ACLK);
      if (cyc == 0) check_val("first_latency", (n == 32'd0) ? tstat_valid : cmd_valid, 1);
      check_val("trans_ready_busy", trans_ready, 0);
      check_val("stat_ready", stat_ready, mdl_out > 0);
      if (hold_cycles > 0 && cyc == hold_cycles) begin
        check_val("limit_cmds", n_cmd, (n_total < MAXO) ? n_total : MAXO);
        check_val("limit_valid", cmd_valid, 0);
      end
      if (cmd_valid) check_val("outstanding_cap", mdl_out < MAXO, 1);
      if (pend && cmd_valid) begin
        check_val("hold_addr", cmd_addr, pa);
        check_val("hold_bytes", cmd_bytes, pb);
      end
      if (cmd_valid && cmd_ready) begin
        check_val("cmd_after_stop", stop_flag, 0);
        check_val("cmd_extra", n_cmd < n_total, 1);
        if (exp_addr_q.size() > 0) begin
          check_val("cmd_addr", cmd_addr, exp_addr_q.pop_front());
          check_val("cmd_bytes", cmd_bytes, exp_len_q.pop_front());
        end
        mdl_out++; n_cmd++;
      end
      pend = cmd_valid && !cmd_ready; pa = cmd_addr; pb = cmd_bytes;
      if (stat_valid && stat_ready) begin
        mdl_out--;
        if (stat_data != 2'b00) begin
          if (mdl_err == 2'b00) mdl_err = stat_data;
          stop_flag = 1'b1;
        end
        if (force_q.size() > 0) void'(force_q.pop_front());
      end
      if (abort && !tstat_valid) begin
        if (mdl_err == 2'b00) mdl_err = 2'b11;
        stop_flag = 1'b1;
      end
      if (tstat_valid) begin
        check_val("drain_outstanding", mdl_out, 0);
        check_val("tstat_data", tstat_data, mdl_err);
        if (tstat_ready) begin
          done = 1'b1;
          if (mdl_err == 2'b00) check_val("all_cmds_issued", n_cmd, n_total);
        end
      end
      @(posedge ACLK); #1;
      cmd_ready   = ($urandom_range(99) < rdy_pct);
      stat_valid  = (cyc + 1 >= hold_cycles) && ($urandom_range(99) < stat_pct);
      stat_data   = (force_q.size() > 0) ? force_q[0] :
                    (($urandom_range(99) < err_pct) ? 2'($urandom_range(3)) : 2'b00);
      tstat_ready = ($urandom_range(99) < tready_pct);
      abort       = abort_after_first && !abort_done && (n_cmd == 1);
      if (abort) abort_done = 1'b1;
      cyc++;
    end
    check_val("transfer_timeout", done, 1);
    check_val("trans_ready_again", trans_ready, 1);
    cmd_ready = 1'b0; stat_valid = 1'b0; tstat_ready = 1'b0; abort = 1'b0;
  endtask

  initial begin
    logic [31:0] ra, rn;
    repeat (3) @(posedge ACLK);
    #1 ARESETn = 1'b1;
    @(negedge ACLK);
    check_val("rst_trans_ready", trans_ready, 1);
    check_val("rst_cmd_valid", cmd_valid, 0);
    check_val("rst_tstat_valid", tstat_valid, 0);
    check_val("rst_stat_ready", stat_ready, 0);
    check_val("rst_cmd_addr", cmd_addr, 0);
    check_val("rst_cmd_bytes", cmd_bytes, 0);
    check_val("rst_tstat_data", tstat_data, 0);
    @(posedge ACLK); #1;

    // Unaligned start, three chunks, all OK
    run_transfer(32'h1000_0100, 32'd5000);
    // Zero-byte transfer
    run_transfer(32'h0000_0040, 32'd0);
    // Outstanding limit with statuses withheld
    hold_cycles = 20;
    run_transfer(32'h0000_0000, 32'd20000);
    hold_cycles = 0;
    // First error kept: second status 10, third 01
    force_q = '{2'b00, 2'b10, 2'b01};
    stat_pct = 60;
    run_transfer(32'h0000_0000, 32'd10000);
    force_q.delete();
`ifdef DMA_SPLITTER_ABORT_EN
    stat_pct = 100;
    abort_after_first = 1'b1;
    run_transfer(32'h1000_0100, 32'd5000);
    check_val("abort_cut", n_cmd < n_total, 1);
    abort_after_first = 1'b0;
`endif

    // Randomized transfers
    for (int t = 0; t < 25; t++) begin
      rdy_pct    = $urandom_range(30, 100);
      stat_pct   = $urandom_range(20, 100);
      err_pct    = ($urandom_range(3) == 0) ? 10 : 0;
      tready_pct = $urandom_range(30, 100);
      case ($urandom_range(3))
        0:       ra = 32'hFFFF_F800 + 32'($urandom_range(2047));
        default: ra = $urandom;
      endcase
      case ($urandom_range(9))
        0:       rn = 32'd0;
        1:       rn = 32'($urandom_range(1, 16));
        default: rn = 32'($urandom_range(1, 12000));
      endcase
      run_transfer(ra, rn);
    end

    // Reset in the middle of issuing
    rdy_pct = 100; stat_pct = 100; err_pct = 0; tready_pct = 100;
    trans_addr = 32'h0; trans_bytes = 32'd20000; trans_valid = 1'b1;
    @(posedge ACLK); #1;
    trans_valid = 1'b0; cmd_ready = 1'b1;
    repeat (2) @(posedge ACLK);
    #1 ARESETn = 1'b0;
    #1;
    check_val("midrst_cmd_valid", cmd_valid, 0);
    check_val("midrst_tstat_valid", tstat_valid, 0);
    check_val("midrst_stat_ready", stat_ready, 0);
    check_val("midrst_cmd_addr", cmd_addr, 0);
    check_val("midrst_cmd_bytes", cmd_bytes, 0);
    check_val("midrst_trans_ready", trans_ready, 1);
    cmd_ready = 1'b0;
    @(posedge ACLK); #1 ARESETn = 1'b1;
    run_transfer(32'h0000_07F0, 32'd4200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
